// File: rtl/alu_pkg.sv
// alu_pkg -- shared types for the pipelined ALU.
//   alu_op_e    : 3-bit operation select carried on alu_pipe.opcode
//   alu_state_e : control FSM states of alu_pipe
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq -- sequential shift-add unsigned multiplier.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset (aborts a run)
//   start          : load a/b and begin; takes exactly WIDTH cycles
//   a, b           : operands, sampled only on start
//   done           : single-cycle pulse in the last iteration cycle
//   product        : full 2*WIDTH-bit product, valid while done is high
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic                 busy_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [2*WIDTH-1:0]   mcand_reg;
  logic [WIDTH-1:0]     mplier_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [2*WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0]   acc_next;

  // Partial product: shifted multiplicand gated by the current multiplier LSB.
  generate
    for (genvar gi = 0; gi < 2*WIDTH; gi++) begin : g_addend
      assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
    end
  endgenerate

  assign acc_next = acc_reg + addend;

  // The final accumulation is exposed combinationally so the owner can
  // capture the product on the same edge that retires the last iteration.
  assign done    = busy_reg && (cnt_reg == LAST);
  assign product = acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg   <= 1'b0;
      cnt_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
    end else if (start) begin
      busy_reg   <= 1'b1;
      cnt_reg    <= '0;
      mcand_reg  <= {{WIDTH{1'b0}}, a};
      mplier_reg <= b;
      acc_reg    <= '0;
    end else if (busy_reg) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + 1'b1;
      if (cnt_reg == LAST) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe -- valid/ready ALU with one-cycle logic/arith ops and a
// WIDTH-cycle sequential multiply.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid, in_ready         : request handshake
//   opcode                     : alu_op_e operation select
//   data_a, data_b             : operands
//   out_valid, out_ready       : result handshake
//   result                     : registered result, held until consumed
//   flag_c, flag_z, flag_v     : carry/borrow, zero, signed overflow
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_v
);

  localparam int SH_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  alu_state_e state_reg, state_next;

  logic [WIDTH-1:0] result_reg;
  logic             c_reg, z_reg, v_reg;

  logic             is_mul;
  logic             load_alu;
  logic             load_mul;
  logic             mul_start;
  logic             mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [SH_W-1:0]  sh_amt;
  logic [WIDTH:0]   add_ext, sub_ext, shl_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [WIDTH-1:0] mul_res;
  logic             mul_c;

  assign is_mul = (opcode == OP_MUL);

  // ---------------- single-cycle datapath ----------------
  assign sh_amt  = data_b[SH_W-1:0];
  assign add_ext = {1'b0, data_a} + {1'b0, data_b};
  assign sub_ext = {1'b0, data_a} - {1'b0, data_b};
  // Bit WIDTH of the widened shift is the last bit pushed out (0 for shift 0).
  assign shl_ext = {1'b0, data_a} << sh_amt;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res = add_ext[WIDTH-1:0];
        alu_c   = add_ext[WIDTH];
        alu_v   = (data_a[WIDTH-1] == data_b[WIDTH-1]) &&
                  (add_ext[WIDTH-1] != data_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_ext[WIDTH-1:0];
        alu_c   = sub_ext[WIDTH];  // borrow == (a < b) unsigned
        alu_v   = (data_a[WIDTH-1] != data_b[WIDTH-1]) &&
                  (sub_ext[WIDTH-1] != data_a[WIDTH-1]);
      end
      OP_AND: alu_res = data_a & data_b;
      OP_OR:  alu_res = data_a | data_b;
      OP_XOR: alu_res = data_a ^ data_b;
      OP_SHL: begin
        alu_res = shl_ext[WIDTH-1:0];
        alu_c   = shl_ext[WIDTH];
      end
      OP_SHR: alu_res = data_a >> sh_amt;
      default: ;  // OP_MUL goes through the sequential multiplier
    endcase
  end

  // ---------------- multiplier ----------------
  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (data_a),
    .b       (data_b),
    .done    (mul_done),
    .product (mul_product)
  );

  assign mul_res = mul_product[WIDTH-1:0];
  assign mul_c   = |mul_product[2*WIDTH-1:WIDTH];

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    load_alu   = 1'b0;
    load_mul   = 1'b0;
    mul_start  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = is_mul ? MUL : HOLD;
          load_alu   = !is_mul;
          mul_start  = is_mul;
        end
      end
      MUL: begin
        // Done is only honoured here, so a stray pulse can never create output.
        if (mul_done) begin
          state_next = HOLD;
          load_mul   = 1'b1;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            state_next = is_mul ? MUL : HOLD;
            load_alu   = !is_mul;
            mul_start  = is_mul;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- result/flag registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg <= '0;
      c_reg      <= 1'b0;
      z_reg      <= 1'b0;
      v_reg      <= 1'b0;
    end else if (load_alu) begin
      result_reg <= alu_res;
      c_reg      <= alu_c;
      z_reg      <= (alu_res == '0);
      v_reg      <= alu_v;
    end else if (load_mul) begin
      result_reg <= mul_res;
      c_reg      <= mul_c;
      z_reg      <= (mul_res == '0);
      v_reg      <= 1'b0;
    end
  end

  assign result = result_reg;
  assign flag_c = c_reg;
  assign flag_z = z_reg;
  assign flag_v = v_reg;

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, as the operand/result width in bits (legal range 4..32).
REQ-002 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1, request presented.
REQ-005 The block SHALL have port in_ready, output, 1, request accepted when in_valid && in_ready.
REQ-006 The block SHALL have port opcode, input, 3, operation select (alu_pkg::alu_op_e).
REQ-007 The block SHALL have ports data_a and data_b, input, WIDTH, operands.
REQ-008 The block SHALL have port out_valid, output, 1, result present.
REQ-009 The block SHALL have port out_ready, input, 1, result consumed when out_valid && out_ready.
REQ-010 The block SHALL have port result, output, WIDTH, operation result.
REQ-011 The block SHALL have ports flag_c, flag_z and flag_v, output, 1 each: carry/borrow, zero and signed overflow.

Function
REQ-012 The opcodes SHALL be: 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 SHL (a << b[log2(WIDTH)-1:0]), 6 SHR logical, 7 MUL (unsigned, low WIDTH bits).
REQ-013 The FSM SHALL have states IDLE, MUL, HOLD.
REQ-014 IDLE: in_ready=1, out_valid=0; on accept of a non-MUL op, the registered result/flags SHALL appear next cycle in HOLD (latency 1).
REQ-015 IDLE: on accept of MUL, the FSM SHALL enter MUL and run a shift-add of exactly WIDTH cycles, then enter HOLD (latency WIDTH+1).
REQ-016 MUL: in_ready=0, out_valid=0, and the operands SHALL be captured at accept so input changes have no effect.
REQ-017 HOLD: out_valid=1, and result/flags SHALL stay stable until out_ready.
REQ-018 HOLD with out_ready=1: in_ready=1; a simultaneous accept SHALL go to HOLD (non-MUL, new result) or MUL; otherwise the FSM SHALL go to IDLE. This gives one result per cycle under no backpressure.
REQ-019 HOLD with out_ready=0: in_ready=0.
REQ-020 flag_z SHALL be 1 when result == 0, for all ops.
REQ-021 flag_c SHALL be: ADD carry-out; SUB borrow (a < b unsigned); SHL last bit shifted out (0 if shift amount 0); SHR 0; MUL 1 if any product bit above WIDTH-1 is nonzero; logic ops 0.
REQ-022 flag_v SHALL be two's-complement overflow for ADD/SUB; 0 for all other ops.
REQ-023 out_ready while out_valid=0 SHALL be ignored; in_valid while in_ready=0 SHALL NOT be accepted.

Reset
REQ-024 Asserting rst_n low SHALL immediately force IDLE, out_valid=0, result=0 and all flags 0; in_ready SHALL be 1 during and after reset.
REQ-025 Reset in MUL or HOLD SHALL abort the operation with no output produced after release.
REQ-026 The first accept SHALL be possible in the first clock after rst_n deasserts.

Structure
REQ-027 Package alu_pkg SHALL hold alu_op_e (3-bit enum of the REQ-012 opcodes) and the alu_state_e FSM enum.
REQ-028 The multiplier SHALL be sub-module alu_mul_seq (start, a, b -> done pulse, product[2*WIDTH-1:0]), with alu_pipe gating its done into HOLD.

Verification (WIDTH=8)
REQ-029 ADD 8'hFF+8'h01, out_ready=1 -> next cycle result 8'h00, c=1, z=1, v=0.
REQ-030 SUB 8'h80-8'h01 -> result 8'h7F, c=0, v=1; then SUB 8'h03-8'h05 -> 8'hFE, c=1.
REQ-031 MUL 8'h10*8'h11 -> out_valid exactly 9 cycles after accept, result 8'h10, c=1; in_ready=0 throughout MUL.
REQ-032 Back-to-back ADD/XOR/SHL with in_valid and out_ready held 1 -> one result per cycle, in order; SHL 8'h81<<1 -> 8'h02, c=1.
REQ-033 Backpressure: out_ready=0 for 5 cycles in HOLD -> result/flags stable, in_ready=0, no accept; then out_ready=1 -> completes.
REQ-034 rst_n pulsed low mid-MUL (cycle 4) -> out_valid=0 immediately, in_ready=1, no result emitted after release.
